// File: rtl/fetch_buffer.sv
// fetch_buffer: dual-ported instruction FIFO between fetch and decode.
// Fetch pushes up to two instructions per cycle, and decode pops up to two per
// cycle. Out slot 1 always holds the older instruction. The outputs are driven
// only from registered state, so there is no combinational input-to-output path.
//
// Handshake: fetch may push only while in_ready is high. in_ready depends only
// on the registered count, so a pop in the same cycle cannot free space for a
// push. While in_ready is low, fetch holds its inputs and the buffer ignores
// them. When out_ready is high, decode takes every valid out slot in that
// cycle; it never takes only part of the valid slots. flush takes priority over
// both push and pop.
module fetch_buffer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [1:0]            in_valid,
  input  logic [1:0][31:0]      in_pc,
  input  logic [1:0][31:0]      in_instr,
  output logic                  in_ready,
  output logic [1:0]            out_valid,
  output logic [1:0][31:0]      out_pc,
  output logic [1:0][31:0]      out_instr,
  input  logic                  out_ready,
  output logic [PTR_W:0]        count
);

  localparam logic [PTR_W:0] LP_PUSH_LIM = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] LP_DEPTH    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LP_ONE      = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] LP_TWO      = (PTR_W+1)'(2);

  // Entry storage. It is not reset; the head, tail and count registers decide
  // which entries are valid.
  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_push_n;
  logic [1:0]       w_pop_n;
  logic [PTR_W-1:0] w_head_p1;
  logic [PTR_W-1:0] w_tail_p1;
  logic             w_wr_a;
  logic             w_wr_b;
  logic [31:0]      w_a_pc;
  logic [31:0]      w_a_instr;
  logic [PTR_W:0]   w_count_next;

  assign w_head_p1 = r_head + PTR_W'(1);
  assign w_tail_p1 = r_tail + PTR_W'(1);

  // Accept a push only while two free entries are guaranteed.
  assign in_ready = (r_count <= LP_PUSH_LIM);
  assign w_push   = in_ready && !flush;
  assign w_pop    = out_ready && !flush;
  assign count    = r_count;

  // Work out how many entries are pushed and popped, and which slot is written
  // to the tail entry.
  always_comb begin
    w_push_n  = 2'd0;
    w_pop_n   = 2'd0;
    w_wr_a    = 1'b0;
    w_wr_b    = 1'b0;
    w_a_pc    = in_pc[0];
    w_a_instr = in_instr[0];
    if (w_push) begin
      case (in_valid)
        2'b11: begin
          w_push_n  = 2'd2;
          w_wr_a    = 1'b1;
          w_wr_b    = 1'b1;
          w_a_pc    = in_pc[1];
          w_a_instr = in_instr[1];
        end
        2'b10: begin
          w_push_n  = 2'd1;
          w_wr_a    = 1'b1;
          w_a_pc    = in_pc[1];
          w_a_instr = in_instr[1];
        end
        2'b01: begin
          w_push_n  = 2'd1;
          w_wr_a    = 1'b1;
        end
        default: begin
          w_push_n  = 2'd0;
        end
      endcase
    end
    if (w_pop) begin
      if (r_count >= LP_TWO)      w_pop_n = 2'd2;
      else if (r_count == LP_ONE) w_pop_n = 2'd1;
      else                        w_pop_n = 2'd0;
    end
  end

  assign w_count_next = r_count
                      + {{(PTR_W-1){1'b0}}, w_push_n}
                      - {{(PTR_W-1){1'b0}}, w_pop_n};

  // Write accepted instructions. The older instruction goes to the tail entry
  // and the younger one to the entry after it.
  always_ff @(posedge clk) begin
    if (w_wr_a) begin
      r_pc[r_tail]    <= w_a_pc;
      r_instr[r_tail] <= w_a_instr;
    end
    if (w_wr_b) begin
      r_pc[w_tail_p1]    <= in_pc[0];
      r_instr[w_tail_p1] <= in_instr[0];
    end
  end

  // Update the pointers and count. Reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_n);
      r_tail  <= r_tail + PTR_W'(w_push_n);
      r_count <= w_count_next;
    end
  end

  // Present the oldest one or two entries. Any slot that is not valid reads as zero.
  always_comb begin
    out_valid    = 2'b00;
    out_pc       = '0;
    out_instr    = '0;
    if (r_count >= LP_TWO) begin
      out_valid    = 2'b11;
      out_pc[1]    = r_pc[r_head];
      out_instr[1] = r_instr[r_head];
      out_pc[0]    = r_pc[w_head_p1];
      out_instr[0] = r_instr[w_head_p1];
    end else if (r_count == LP_ONE) begin
      out_valid    = 2'b10;
      out_pc[1]    = r_pc[r_head];
      out_instr[1] = r_instr[r_head];
    end
  end

  // Occupancy can never exceed the number of entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (r_count <= LP_DEPTH)
        else $error("fetch_buffer count overflow: %0d", r_count);
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed scenario tasks plus a queue-model random phase for fetch_buffer.
module tb_fetch_buffer;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic             clk;
  logic             reset;
  logic             flush;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_pc;
  logic [1:0][31:0] in_instr;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_pc;
  logic [1:0][31:0] out_instr;
  logic             out_ready;
  logic [PTR_W:0]   count;

  int n_checks;
  int n_errors;

  fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive fetch inputs; the instruction word is the inverted PC so the data path is checked too.
  task automatic drive(input logic [1:0] v, input logic [31:0] pc1, input logic [31:0] pc0);
    in_valid    = v;
    in_pc[1]    = pc1;
    in_pc[0]    = pc0;
    in_instr[1] = ~pc1;
    in_instr[0] = ~pc0;
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 32'h0);
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 2'b00) begin
      n_errors++; $display("FAIL reset_out_valid: got %b want 00", out_valid);
    end
    n_checks++;
    if (out_pc !== 64'h0 || out_instr !== 64'h0) begin
      n_errors++; $display("FAIL reset_out_data: got pc %h instr %h want 0", out_pc, out_instr);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_checks++;
    if (count !== 5'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d want 0", count);
    end
  endtask

  task automatic test_pair_push();
    idle();
    drive(2'b11, 32'h1000, 32'h1004);
    tick();
    idle();
    n_checks++;
    if (out_valid !== 2'b11) begin
      n_errors++; $display("FAIL pair_valid: got %b want 11", out_valid);
    end
    n_checks++;
    if (out_pc[1] !== 32'h1000 || out_pc[0] !== 32'h1004) begin
      n_errors++; $display("FAIL pair_pc: got %h/%h want 1000/1004", out_pc[1], out_pc[0]);
    end
    n_checks++;
    if (out_instr[1] !== ~32'h1000 || out_instr[0] !== ~32'h1004) begin
      n_errors++; $display("FAIL pair_instr: got %h/%h want %h/%h", out_instr[1], out_instr[0],
                           ~32'h1000, ~32'h1004);
    end
    n_checks++;
    if (count !== 5'd2) begin
      n_errors++; $display("FAIL pair_count: got %0d want 2", count);
    end
    do_flush();
  endtask

  task automatic test_singles();
    idle();
    drive(2'b10, 32'h2000, 32'hDEAD);
    tick();
    drive(2'b01, 32'hBEEF, 32'h2004);
    tick();
    drive(2'b10, 32'h2008, 32'hDEAD);
    tick();
    idle();
    n_checks++;
    if (count !== 5'd3) begin
      n_errors++; $display("FAIL singles_count: got %0d want 3", count);
    end
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 2'b11 || out_pc[1] !== 32'h2000 || out_pc[0] !== 32'h2004) begin
      n_errors++; $display("FAIL singles_pop1: got %b %h/%h want 11 2000/2004",
                           out_valid, out_pc[1], out_pc[0]);
    end
    tick();
    n_checks++;
    if (out_valid !== 2'b10 || out_pc[1] !== 32'h2008 || out_pc[0] !== 32'h0 || count !== 5'd1) begin
      n_errors++; $display("FAIL singles_pop2: got %b %h/%h cnt %0d want 10 2008/0 cnt 1",
                           out_valid, out_pc[1], out_pc[0], count);
    end
    tick();
    n_checks++;
    if (out_valid !== 2'b00 || count !== 5'd0) begin
      n_errors++; $display("FAIL singles_empty: got %b cnt %0d want 00 cnt 0", out_valid, count);
    end
    // Popping an empty buffer must have no effect.
    tick();
    n_checks++;
    if (count !== 5'd0 || out_valid !== 2'b00) begin
      n_errors++; $display("FAIL empty_pop: got cnt %0d valid %b want 0 00", count, out_valid);
    end
    idle();
  endtask

  // Fill to full, check that held inputs are ignored, then check push and pop in
  // the same cycle at count 15 and count 13 across the pointer wrap.
  task automatic test_fill_wrap();
    logic [31:0] exp_pc [13];
    idle();
    do_flush();
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_errors++; $display("FAIL fill_ready_%0d: got %b want 1 at count %0d", k, in_ready, count);
      end
      drive(2'b11, 32'h3000 + 32'(8*k), 32'h3004 + 32'(8*k));
      tick();
    end
    n_checks++;
    if (count !== 5'd16 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL fill_full: got cnt %0d rdy %b want 16 0", count, in_ready);
    end
    // Held inputs while full must not be written.
    drive(2'b11, 32'h3F00, 32'h3F04);
    tick();
    n_checks++;
    if (count !== 5'd16 || out_pc[1] !== 32'h3000) begin
      n_errors++; $display("FAIL full_hold: got cnt %0d head %h want 16 3000", count, out_pc[1]);
    end
    // Pop while full: the push stays blocked and count drops to 14.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (count !== 5'd14 || out_pc[1] !== 32'h3008) begin
      n_errors++; $display("FAIL full_pop: got cnt %0d head %h want 14 3008", count, out_pc[1]);
    end
    drive(2'b10, 32'h3080, 32'h0);
    tick();
    n_checks++;
    if (count !== 5'd15 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL cnt15: got cnt %0d rdy %b want 15 0", count, in_ready);
    end
    // At count 15 a pair push is rejected and the pop still happens.
    drive(2'b11, 32'h3090, 32'h3094);
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (count !== 5'd13 || out_pc[1] !== 32'h3010) begin
      n_errors++; $display("FAIL cnt15_pushpop: got cnt %0d head %h want 13 3010", count, out_pc[1]);
    end
    // At count 13, push a pair and pop a pair in the same cycle.
    drive(2'b11, 32'h30A0, 32'h30A4);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    out_ready = 1'b0;
    n_checks++;
    if (count !== 5'd13) begin
      n_errors++; $display("FAIL cnt13_pushpop: got cnt %0d want 13", count);
    end
    for (int i = 0; i < 10; i++) exp_pc[i] = 32'h3018 + 32'(4*i);
    exp_pc[10] = 32'h3080;
    exp_pc[11] = 32'h30A0;
    exp_pc[12] = 32'h30A4;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i += 2) begin
      n_checks++;
      if (out_valid !== 2'b11 || out_pc[1] !== exp_pc[i] || out_pc[0] !== exp_pc[i+1]) begin
        n_errors++; $display("FAIL wrap_order_%0d: got %b %h/%h want 11 %h/%h", i, out_valid,
                             out_pc[1], out_pc[0], exp_pc[i], exp_pc[i+1]);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 2'b10 || out_pc[1] !== exp_pc[12]) begin
      n_errors++; $display("FAIL wrap_last: got %b %h want 10 %h", out_valid, out_pc[1], exp_pc[12]);
    end
    tick();
    n_checks++;
    if (count !== 5'd0) begin
      n_errors++; $display("FAIL wrap_drained: got cnt %0d want 0", count);
    end
    idle();
  endtask

  task automatic test_flush();
    idle();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'h4000 + 32'(8*k), 32'h4004 + 32'(8*k));
      tick();
    end
    n_checks++;
    if (count !== 5'd6) begin
      n_errors++; $display("FAIL flush_pre: got cnt %0d want 6", count);
    end
    drive(2'b11, 32'h4F00, 32'h4F04);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    idle();
    n_checks++;
    if (count !== 5'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL flush_state: got cnt %0d valid %b rdy %b want 0 00 1",
                           count, out_valid, in_ready);
    end
    drive(2'b11, 32'h5000, 32'h5004);
    tick();
    idle();
    n_checks++;
    if (count !== 5'd2 || out_pc[1] !== 32'h5000 || out_pc[0] !== 32'h5004) begin
      n_errors++; $display("FAIL flush_after: got cnt %0d %h/%h want 2 5000/5004",
                           count, out_pc[1], out_pc[0]);
    end
    // Asserting reset mid-operation empties the buffer just like flush.
    drive(2'b11, 32'h6000, 32'h6004);
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    n_checks++;
    if (count !== 5'd0 || out_valid !== 2'b00) begin
      n_errors++; $display("FAIL reset_mid: got cnt %0d valid %b want 0 00", count, out_valid);
    end
  endtask

  // Random push/pop/flush traffic checked against a queue model.
  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] next_pc;
    logic [31:0] e1;
    logic [31:0] e0;
    logic [1:0]  ev;
    logic        acc;
    int          pop_n;
    int          sz;
    idle();
    do_flush();
    next_pc = 32'h0001_0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive(2'($urandom_range(0, 3)), next_pc, next_pc + 32'h4);
      out_ready = ($urandom_range(0, 99) < 45);
      flush     = ($urandom_range(0, 99) < 2);
      sz = exp_q.size();
      ev = (sz >= 2) ? 2'b11 : (sz == 1) ? 2'b10 : 2'b00;
      e1 = (sz >= 1) ? exp_q[0] : 32'h0;
      e0 = (sz >= 2) ? exp_q[1] : 32'h0;
      n_checks++;
      if (count !== 5'(sz) || in_ready !== (sz <= DEPTH - 2)) begin
        n_errors++; $display("FAIL rand_count_%0d: got cnt %0d rdy %b want %0d", cyc, count,
                             in_ready, sz);
      end
      n_checks++;
      if (out_valid !== ev || out_pc[1] !== e1 || out_pc[0] !== e0
          || out_instr[1] !== (ev[1] ? ~e1 : 32'h0) || out_instr[0] !== (ev[0] ? ~e0 : 32'h0)) begin
        n_errors++; $display("FAIL rand_out_%0d: got %b %h/%h want %b %h/%h", cyc, out_valid,
                             out_pc[1], out_pc[0], ev, e1, e0);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        pop_n = out_ready ? ((sz >= 2) ? 2 : sz) : 0;
        for (int p = 0; p < pop_n; p++) void'(exp_q.pop_front());
        acc = (sz <= DEPTH - 2);
        if (acc && in_valid[1]) exp_q.push_back(in_pc[1]);
        if (acc && in_valid[0]) exp_q.push_back(in_pc[0]);
        if (acc && in_valid != 2'b00) next_pc = next_pc + 32'h8;
      end
      tick();
    end
    idle();
  endtask

  // Run the scenarios in order and print the summary.
  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    idle();
    test_reset();
    test_pair_push();
    test_singles();
    test_fill_wrap();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
